fft_bitrev_reorder: RTL and testbench

//  Streaming consumer at the output of the 16-point radix-2 SDF fft pipeline.
//  The pipeline emits bins in bit-reversed order; this block restores natural order.
//  It uses a ping-pong pair of N-entry complex buffers: write at bitrev(index), read sequentially.
//  It sits between fft and downstream magnitude/IFFT logic; the optional conjugate enables IFFT-by-FFT.

---
 rtl/fft_bitrev_reorder_pkg.sv | 23 ++
 rtl/fft_bitrev_reorder_bank.sv | 37 +++
 rtl/fft_bitrev_reorder.sv | 204 ++++++++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared constants, read-FSM state type and bit-reversal helper for the FFT output reorder block.
package fft_bitrev_reorder_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_LOG2N  = 4;
  localparam int BITS_WIDTH = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverses the low nbits of value; nbits is a constant at every call site.
  function automatic int unsigned bitrev(input int unsigned value, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < nbits; i++) begin
      r = (r << 1) | ((value >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_bank.sv
// One half of the ping-pong store: DEPTH x DW dual-port RAM, synchronous write, registered read.
module fft_bitrev_reorder_bank
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int DEPTH = FFT_N,
  parameter int AW    = FFT_LOG2N,
  parameter int DW    = 2 * BITS_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: storage is deliberately left out of reset so it maps onto RAM; validity is tracked by bank_full.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: state updates use <= so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Restores natural bin order after a radix-2 SDF FFT using ping-pong banks.
// Optional build macro REORDER_CONJ_EN: conjugate (saturating negate) the imaginary output.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int LOG2N = FFT_LOG2N,
  parameter int WIDTH = BITS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic [WIDTH-1:0] in_real,
  input  logic [WIDTH-1:0] in_imag,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [WIDTH-1:0] out_real,
  output logic [WIDTH-1:0] out_imag,
  output logic             sync_err
);

  localparam int DW = 2 * WIDTH;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  // Write side
  logic [LOG2N-1:0] wr_cnt_q;
  logic             wr_bank_q;
  logic             synced_q;
  logic [1:0]       bank_full_q;

  logic             wr_restart;
  logic             wr_fire;
  logic [LOG2N-1:0] wr_idx;
  logic [LOG2N-1:0] wr_addr;
  logic [WIDTH-1:0] imag_w;
  logic [DW-1:0]    wr_data;
  logic [1:0]       set_full;
  logic [1:0]       clr_full;

  // Read side
  rd_state_t        state_q, state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  logic             rd_en;
  logic             rd_sel;
  logic [LOG2N-1:0] rd_addr;
  logic             out_bank_q;
  logic [DW-1:0]    rd_data0;
  logic [DW-1:0]    rd_data1;

`ifdef REORDER_CONJ_EN
  localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
`endif

  // Conjugation is applied on the way in so the output path is a plain register mux.
  always_comb begin
`ifdef REORDER_CONJ_EN
    imag_w = (in_imag == NEG_MAX) ? POS_MAX : -in_imag;
`else
    imag_w = in_imag;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_restart = in_valid && in_sop;
    wr_fire    = in_valid && (in_sop || synced_q);
    wr_idx     = wr_restart ? '0 : wr_cnt_q;
    wr_addr    = LOG2N'(bitrev(32'(wr_idx), LOG2N));
    wr_data    = {in_real, imag_w};
    set_full   = '0;
    if (wr_fire && (wr_idx == LAST)) begin
      set_full[wr_bank_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      synced_q  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= wr_restart && (wr_cnt_q != '0);
      if (wr_restart) begin
        synced_q <= 1'b1;
      end
      if (wr_fire) begin
        if (wr_idx == LAST) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q <= wr_idx + LOG2N'(1);
        end
      end
    end
  end

  // Writer sets and reader clears touch different banks, so both take effect in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_full_q <= '0;
    end else begin
      bank_full_q <= (bank_full_q & ~clr_full) | set_full;
    end
  end

  // Read FSM. The IDLE branch issues bin 0 directly so a frame appears one edge after it completes.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_en     = 1'b0;
    rd_sel    = rd_bank_q;
    rd_addr   = rd_cnt_q;
    clr_full  = '0;
    case (state_q)
      RD_IDLE: begin
        if (|bank_full_q) begin
          rd_sel    = bank_full_q[0] ? 1'b0 : 1'b1;
          rd_en     = 1'b1;
          rd_addr   = '0;
          rd_bank_d = rd_sel;
          rd_cnt_d  = LOG2N'(1);
          state_d   = RD_READ;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if (rd_cnt_q == LAST) begin
          clr_full[rd_bank_q] = 1'b1;
          rd_cnt_d            = '0;
          if (bank_full_q[~rd_bank_q]) begin
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d = RD_IDLE;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + LOG2N'(1);
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_bank_q <= 1'b0;
    end else begin
      out_valid <= rd_en;
      out_sop   <= rd_en && (rd_addr == '0);
      out_eop   <= rd_en && (rd_addr == LAST);
      if (rd_en) begin
        out_bank_q <= rd_sel;
      end
    end
  end

  fft_bitrev_reorder_bank #(.DEPTH(N), .AW(LOG2N), .DW(DW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire && !wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en && !rd_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  fft_bitrev_reorder_bank #(.DEPTH(N), .AW(LOG2N), .DW(DW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_fire && wr_bank_q),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en && rd_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  always_comb begin
    out_real = out_bank_q ? rd_data1[DW-1:WIDTH] : rd_data0[DW-1:WIDTH];
    out_imag = out_bank_q ? rd_data1[WIDTH-1:0]  : rd_data0[WIDTH-1:0];
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder: randomized frames against a frame-level reorder model.
module tb_fft_bitrev_reorder;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int W     = 16;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sop;
    logic         eop;
    int           cyc;
  } beat_t;

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         sop;
    logic         eop;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic [W-1:0] in_real = '0;
  logic [W-1:0] in_imag = '0;
  logic         out_valid, out_sop, out_eop, sync_err;
  logic [W-1:0] out_real, out_imag;

  int checks = 0;
  int failures = 0;

  fft_bitrev_reorder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    serr_cnt = 0;
  beat_t obs_q[$];
  always @(negedge clk) begin
    if (sync_err) serr_cnt <= serr_cnt + 1;
    if (out_valid) obs_q.push_back(beat_t'{out_real, out_imag, out_sop, out_eop, cyc});
  end

  // Reference model: collects whole frames in arrival order and emits natural order.
  exp_t         exp_q[$];
  int           end_q[$];
  int           m_cnt = 0;
  bit           m_synced = 1'b0;
  logic [W-1:0] m_re[N];
  logic [W-1:0] m_im[N];
  int           exp_serr = 0;
  int           serr_base = 0;

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] model_imag(input logic [W-1:0] im);
`ifdef REORDER_CONJ_EN
    int v;
    v = -int'($signed(im));
    if (v > 32767) v = 32767;
    return W'(v);
`else
    return im;
`endif
  endfunction

  function automatic logic [W-1:0] rand16();
    if ($urandom_range(0, 7) == 0) return 16'h8000;
    return W'($urandom);
  endfunction

  task automatic send(input logic v, input logic s, input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    in_valid = v;
    in_sop   = s;
    in_real  = re;
    in_imag  = im;
    if (v) begin
      if (s) begin
        if (m_cnt != 0) exp_serr++;
        m_cnt    = 0;
        m_synced = 1'b1;
      end
      if (m_synced) begin
        m_re[m_cnt] = re;
        m_im[m_cnt] = im;
        m_cnt++;
        if (m_cnt == N) begin
          for (int j = 0; j < N; j++) begin
            exp_q.push_back(exp_t'{m_re[brev(j)], model_imag(m_im[brev(j)]), j == 0, j == N - 1});
          end
          end_q.push_back(cyc + 1);
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic send_idle();
    send(1'b0, 1'b0, rand16(), rand16());
  endtask

  task automatic flush();
    obs_q.delete();
    exp_q.delete();
    end_q.delete();
    exp_serr  = 0;
    serr_base = serr_cnt;
  endtask

  task automatic check_stream(input string tag);
    int n;
    bit ok;
    repeat (2 * N + 4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s count: got %0d beats, want %0d", tag, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i].re !== exp_q[i].re || obs_q[i].im !== exp_q[i].im ||
          obs_q[i].sop !== exp_q[i].sop || obs_q[i].eop !== exp_q[i].eop) begin
        failures++;
        $display("FAIL %s beat %0d: got re=%h im=%h sop=%b eop=%b, want re=%h im=%h sop=%b eop=%b",
                 tag, i, obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop);
      end
    end
    for (int f = 0; f < end_q.size(); f++) begin
      if (f * N + N - 1 < obs_q.size()) begin
        checks++;
        if (obs_q[f * N].cyc != end_q[f] + 1) begin
          failures++;
          $display("FAIL %s latency frame %0d: bin0 at edge %0d, want %0d",
                   tag, f, obs_q[f * N].cyc, end_q[f] + 1);
        end
        ok = 1'b1;
        for (int j = 1; j < N; j++) begin
          if (obs_q[f * N + j].cyc != obs_q[f * N].cyc + j) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s contiguity frame %0d: got gaps, want %0d consecutive beats", tag, f, N);
        end
      end
    end
    checks++;
    if (serr_cnt - serr_base != exp_serr) begin
      failures++;
      $display("FAIL %s sync_err: got %0d pulse cycles, want %0d", tag, serr_cnt - serr_base, exp_serr);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({out_valid, out_sop, out_eop, sync_err} !== 4'b0 || out_real !== '0 || out_imag !== '0) begin
      failures++;
      $display("FAIL %s: got valid=%b sop=%b eop=%b serr=%b re=%h im=%h, want all 0",
               tag, out_valid, out_sop, out_eop, sync_err, out_real, out_imag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_initial");
    rst = 1'b1;
    for (int i = 0; i < N; i++) send(1'b1, i == 0, rand16(), rand16());
    for (int i = 0; i < 7; i++) send(1'b1, i == 0, rand16(), rand16());
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre: got out_valid=%b, want 1", out_valid);
    end
    #2 rst = 1'b0;
    #1 check_idle_outputs("reset_async");
    in_valid = 1'b0;
    in_sop   = 1'b0;
    m_cnt    = 0;
    m_synced = 1'b0;
    flush();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_released");
    flush();
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, rand16(), rand16());
    for (int i = 0; i < N; i++) send(1'b1, i == 0, rand16(), rand16());
    send_idle();
    check_stream("reset_first_frame");
    flush();
  endtask

  task automatic test_ramp();
    int ramp_tab[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    for (int i = 0; i < N; i++) send(1'b1, i == 0, W'(i), rand16());
    send_idle();
    check_stream("ramp");
    if (obs_q.size() >= N) begin
      for (int j = 0; j < N; j++) begin
        checks++;
        if (obs_q[j].re !== W'(ramp_tab[j])) begin
          failures++;
          $display("FAIL ramp_order bin %0d: got %0d, want %0d", j, obs_q[j].re, ramp_tab[j]);
        end
      end
      checks++;
      if (obs_q[0].sop !== 1'b1 || obs_q[N - 1].eop !== 1'b1) begin
        failures++;
        $display("FAIL ramp_marks: got sop=%b eop=%b, want 1 1", obs_q[0].sop, obs_q[N - 1].eop);
      end
    end
    flush();
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) send(1'b1, i == 0, rand16(), rand16());
    end
    send_idle();
    check_stream("back_to_back");
    checks++;
    if (obs_q.size() != 3 * N) begin
      failures++;
      $display("FAIL b2b_run: got %0d beats, want %0d", obs_q.size(), 3 * N);
    end else if (obs_q[3 * N - 1].cyc - obs_q[0].cyc != 3 * N - 1) begin
      failures++;
      $display("FAIL b2b_run: got span %0d, want %0d", obs_q[3 * N - 1].cyc - obs_q[0].cyc, 3 * N - 1);
    end
    flush();
  endtask

  task automatic test_gappy();
    int sent;
    for (int i = 0; i < 2 * N; i++) begin
      if (i % 2 == 0) send(1'b1, i == 0, rand16(), rand16());
      else send_idle();
    end
    sent = 0;
    while (sent < N) begin
      if ($urandom_range(0, 1) == 1) begin
        send(1'b1, sent == 0, rand16(), rand16());
        sent++;
      end else begin
        send_idle();
      end
    end
    send_idle();
    check_stream("gappy");
    flush();
  endtask

  task automatic test_sync_err();
    for (int i = 0; i < 5; i++) send(1'b1, i == 0, rand16(), rand16());
    for (int i = 0; i < N; i++) send(1'b1, i == 0, rand16(), rand16());
    send_idle();
    check_stream("sync_err");
    checks++;
    if (serr_cnt - serr_base != 1) begin
      failures++;
      $display("FAIL sync_err_once: got %0d, want 1", serr_cnt - serr_base);
    end
    flush();
  endtask

  task automatic test_conj();
    logic [W-1:0] im_in[3] = '{16'h0003, 16'hFFFC, 16'h8000};
    int           pos[3] = '{0, 8, 4};
`ifdef REORDER_CONJ_EN
    logic [W-1:0] im_out[3] = '{16'hFFFD, 16'h0004, 16'h7FFF};
`else
    logic [W-1:0] im_out[3] = '{16'h0003, 16'hFFFC, 16'h8000};
`endif
    for (int i = 0; i < N; i++) send(1'b1, i == 0, rand16(), (i < 3) ? im_in[i] : rand16());
    send_idle();
    check_stream("conj");
    if (obs_q.size() >= N) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_q[pos[k]].im !== im_out[k]) begin
          failures++;
          $display("FAIL conj_value %0d: got %h, want %h", k, obs_q[pos[k]].im, im_out[k]);
        end
      end
    end
    flush();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_gappy();
    test_sync_err();
    test_conj();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
